// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: state encoding, handshake levels, default widths.
package div_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] divisor,
    input  logic              dividend_bit,
    output logic [DATA_W:0]   rem_next,
    output logic              quotient_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;

    always_comb begin
        shifted      = {rem, dividend_bit};
        trial        = shifted - {2'b00, divisor};
        // top bit of the trial difference is the borrow: set means the divisor did not fit
        quotient_bit = ~trial[DATA_W+1];
        rem_next     = quotient_bit ? trial[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/div.sv
// Multi-cycle signed/unsigned integer divider returning {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: short path when |divisor| > |dividend|.
//
// state      | meaning
// DIV_FREE   | idle, waiting for start_i (annul_i blocks acceptance)
// DIV_BYZERO | one-cycle short path (zero divisor or early-out)
// DIV_ON     | DATA_W shift-subtract steps, then sign fix-up
// DIV_END    | result valid, held until start_i drops
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W:0]   rem_next;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] quo;
    logic              q_bit;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
`ifdef DIV_EARLY_OUT_EN
    logic              early;
    logic [DATA_W-1:0] early_rem;
`endif

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        // the most negative value maps onto itself, which is correct read as unsigned
        return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    always_comb begin
        mag1    = magnitude(opdata1_i, signed_div_i);
        mag2    = magnitude(opdata2_i, signed_div_i);
        quo_fix = neg_q ? (~quo + DATA_W'(1)) : quo;
        rem_fix = neg_r ? (~rem[DATA_W-1:0] + DATA_W'(1)) : rem[DATA_W-1:0];
    end

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem          (rem),
        .divisor      (dvs),
        .dividend_bit (dvd[DATA_W-1]),
        .rem_next     (rem_next),
        .quotient_bit (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            quo       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
`ifdef DIV_EARLY_OUT_EN
            early     <= 1'b0;
            early_rem <= '0;
`endif
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (start_i == DIV_START && !annul_i) begin
                        neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r <= signed_div_i & opdata1_i[DATA_W-1];
                        if (opdata2_i == '0) begin
                            state <= DIV_BYZERO;
`ifdef DIV_EARLY_OUT_EN
                            early <= 1'b0;
                        end else if (mag2 > mag1) begin
                            // quotient is zero and the remainder is the dividend itself
                            state     <= DIV_BYZERO;
                            early     <= 1'b1;
                            early_rem <= opdata1_i;
`endif
                        end else begin
                            state <= DIV_ON;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= mag1;
                            dvs   <= mag2;
                            quo   <= '0;
                        end
                    end
                end
                DIV_BYZERO: begin
                    state   <= DIV_END;
                    ready_o <= DIV_RESULT_READY;
`ifdef DIV_EARLY_OUT_EN
                    result_o <= early ? {early_rem, {DATA_W{1'b0}}} : '0;
`else
                    result_o <= '0;
`endif
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                        cnt   <= '0;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        rem <= rem_next;
                        dvd <= {dvd[DATA_W-2:0], 1'b0};
                        quo <= {quo[DATA_W-2:0], q_bit};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                        cnt      <= '0;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
